// File: rtl/pigasus_match_collector_pkg.sv
// pigasus_match_collector_pkg: shared FSM encoding, completion record layout and rd_addr field split
package pigasus_match_collector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // Completion record is packed {slot, count, overflow}, overflow in bit 0.
    localparam int REC_OVF_LSB = 0;
    localparam int REC_CNT_LSB = 1;

    function automatic int rec_width(input int slot_w, input int cnt_w);
        return slot_w + cnt_w + 1;
    endfunction

    function automatic int rec_slot_lsb(input int cnt_w);
        return cnt_w + 1;
    endfunction

    // rd_addr is {slot_idx, match_idx}; match_idx occupies the low bits.
    localparam int RD_MATCH_LSB = 0;

    function automatic int rd_slot_lsb(input int max_matches);
        return $clog2(max_matches);
    endfunction

endpackage

// File: rtl/pigasus_match_collector_done_fifo.sv
// collector_done_fifo: synchronous FIFO with registered head output and full/empty flags
//   clk, rst           clock, async active-high reset
//   in_valid/in_ready  push side; push when both high
//   din                pushed word
//   out_valid/out_ready pop side; pop when both high
//   dout               registered head word (zero when empty)
//   full, empty        occupancy flags
module collector_done_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic [AW:0]      cnt_n;
    logic [AW:0]      cnt_left;
    logic             do_push;
    logic             do_pop;

    assign full     = cnt == (AW+1)'(DEPTH);
    assign empty    = cnt == '0;
    assign in_ready = ~full;
    assign do_push  = in_valid & in_ready;
    assign do_pop   = out_valid & out_ready;
    assign cnt_left = cnt - (AW+1)'(do_pop);
    assign cnt_n    = cnt_left + (AW+1)'(do_push);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= din;
    end

    // dout mirrors the head entry one cycle ahead; when the FIFO is about to
    // hold only the word being pushed, that word bypasses the memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else begin
            wptr      <= wptr + AW'(do_push);
            rptr      <= rptr + AW'(do_pop);
            cnt       <= cnt_n;
            out_valid <= cnt_n != '0;
            dout      <= cnt_n == '0 ? '0 : cnt_left == '0 ? din : mem[rptr + AW'(do_pop)];
        end
    end

endmodule

// File: rtl/pigasus_match_collector.sv
// pigasus_match_collector: drains the SME match stream into a per-slot rule buffer and queues completion records
//   clk, rst                      clock, async active-high reset
//   s_slot_*                      packet slot tags in packet order; s_slot_ready pops a tag
//   s_match_*                     match beats (rule ID or end-of-packet marker)
//   m_done_*                      completion records {slot, count, overflow} for the core
//   rd_en/rd_addr/rd_data/rd_valid buffer read port, one-cycle latency
//   total_matches                 wrapping count of accepted rule beats
module pigasus_match_collector
    import pigasus_match_collector_pkg::*;
#(
    parameter int SLOT_COUNT    = 16,
    parameter int MAX_MATCHES   = 8,
    parameter int RULE_WIDTH    = 16,
    parameter int SLOT_WIDTH    = 8,
    parameter int CNT_WIDTH     = $clog2(MAX_MATCHES+1),
    parameter int RD_ADDR_WIDTH = $clog2(SLOT_COUNT*MAX_MATCHES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_slot_valid,
    input  logic [SLOT_WIDTH-1:0]    s_slot,
    output logic                     s_slot_ready,
    input  logic                     s_match_valid,
    input  logic [RULE_WIDTH-1:0]    s_match_rule_id,
    input  logic                     s_match_eop,
    output logic                     s_match_ready,
    output logic                     m_done_valid,
    output logic [SLOT_WIDTH-1:0]    m_done_slot,
    output logic [CNT_WIDTH-1:0]     m_done_count,
    output logic                     m_done_overflow,
    input  logic                     m_done_ready,
    input  logic                     rd_en,
    input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
    output logic [RULE_WIDTH-1:0]    rd_data,
    output logic                     rd_valid,
    output logic [31:0]              total_matches
);

    localparam int SI_W     = $clog2(SLOT_COUNT);
    localparam int MI_W     = rd_slot_lsb(MAX_MATCHES);
    localparam int REC_W    = rec_width(SLOT_WIDTH, CNT_WIDTH);
    localparam int SLOT_LSB = rec_slot_lsb(CNT_WIDTH);
    localparam int BUF_D    = SLOT_COUNT * MAX_MATCHES;
    localparam logic [CNT_WIDTH-1:0] IDX_MAX = CNT_WIDTH'(MAX_MATCHES);

    state_t                   state;
    state_t                   state_n;
    logic [SLOT_WIDTH-1:0]    slot_q;
    logic [CNT_WIDTH-1:0]     idx;
    logic                     ovf;
    logic                     accept;
    logic                     is_rule;
    logic                     wr_en;
    logic                     push;
    logic                     done_in_ready;
    logic                     done_full;
    logic                     done_empty;
    logic                     done_valid;
    logic [REC_W-1:0]         done_rec;
    logic [RD_ADDR_WIDTH-1:0] wr_addr;
    logic [RULE_WIDTH-1:0]    mem [BUF_D];

    assign accept  = s_match_valid & s_match_ready;
    assign is_rule = accept & ~s_match_eop;
    assign wr_en   = is_rule & (idx != IDX_MAX);
    assign wr_addr = {slot_q[SI_W-1:0], idx[MI_W-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n       = state;
        s_match_ready = 1'b0;
        push          = 1'b0;
        case (state)
            IDLE:    state_n = s_slot_valid ? COLLECT : IDLE;
            COLLECT: begin
                s_match_ready = 1'b1;
                state_n       = (s_match_valid && s_match_eop) ? COMMIT : COLLECT;
            end
            COMMIT:  begin
                push    = done_in_ready;
                state_n = done_full ? COMMIT : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // The slot tag is only popped once its record is safely queued.
    assign s_slot_ready = push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q        <= '0;
            idx           <= '0;
            ovf           <= 1'b0;
            total_matches <= '0;
        end else begin
            if (state == IDLE && s_slot_valid) begin
                slot_q <= s_slot;
                idx    <= '0;
                ovf    <= 1'b0;
            end
            if (wr_en)
                idx <= idx + CNT_WIDTH'(1);
            if (is_rule && idx == IDX_MAX)
                ovf <= 1'b1;
            if (is_rule)
                total_matches <= total_matches + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= s_match_rule_id;
    end

    // Read-first: a same-cycle write to rd_addr is not visible here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= mem[rd_addr];
        end
    end

    collector_done_fifo #(
        .DEPTH (SLOT_COUNT),
        .WIDTH (REC_W)
    ) u_done_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push),
        .in_ready  (done_in_ready),
        .din       ({slot_q, idx, ovf}),
        .out_valid (done_valid),
        .out_ready (m_done_ready),
        .dout      (done_rec),
        .full      (done_full),
        .empty     (done_empty)
    );

    assign m_done_valid    = done_valid & ~done_empty;
    assign m_done_slot     = done_rec[SLOT_LSB +: SLOT_WIDTH];
    assign m_done_count    = done_rec[REC_CNT_LSB +: CNT_WIDTH];
    assign m_done_overflow = done_rec[REC_OVF_LSB];

endmodule

// File: tb/tb_pigasus_match_collector.sv
// tb_pigasus_match_collector: directed and randomized checks against a packet-level reference model
module tb_pigasus_match_collector;

    typedef struct packed {
        logic        eop;
        logic [15:0] rule;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_slot_valid = 1'b0;
    logic [7:0]  s_slot = '0;
    logic        s_slot_ready;
    logic        s_match_valid = 1'b0;
    logic [15:0] s_match_rule_id = '0;
    logic        s_match_eop = 1'b0;
    logic        s_match_ready;
    logic        m_done_valid;
    logic [7:0]  m_done_slot;
    logic [3:0]  m_done_count;
    logic        m_done_overflow;
    logic        m_done_ready = 1'b0;
    logic        rd_en = 1'b0;
    logic [6:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [31:0] total_matches;

    always #5 clk = ~clk;

    pigasus_match_collector dut (
        .clk             (clk),
        .rst             (rst),
        .s_slot_valid    (s_slot_valid),
        .s_slot          (s_slot),
        .s_slot_ready    (s_slot_ready),
        .s_match_valid   (s_match_valid),
        .s_match_rule_id (s_match_rule_id),
        .s_match_eop     (s_match_eop),
        .s_match_ready   (s_match_ready),
        .m_done_valid    (m_done_valid),
        .m_done_slot     (m_done_slot),
        .m_done_count    (m_done_count),
        .m_done_overflow (m_done_overflow),
        .m_done_ready    (m_done_ready),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .total_matches   (total_matches)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  slot_q [$];
    beat_t       beat_q [$];
    logic [12:0] exp_q [$];
    logic [15:0] pkt_rules [$];
    logic [15:0] ref_mem [128];
    bit          ref_ok [128];
    logic [31:0] total_ref = '0;
    bit          bubbles = 0;
    bit          rand_ready = 0;
    bit          ready_on = 1;
    int          cyc = 0;
    int          eop_cyc = -1;
    int          dv_cyc = -1;
    int          first_cyc = -1;
    bit          prev_dv = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        s_slot_valid    = slot_q.size() > 0;
        s_slot          = slot_q.size() > 0 ? slot_q[0] : 8'h00;
        s_match_valid   = beat_q.size() > 0 && !(bubbles && $urandom_range(3) == 0);
        s_match_eop     = beat_q.size() > 0 ? beat_q[0].eop : 1'b0;
        s_match_rule_id = beat_q.size() > 0 ? beat_q[0].rule : 16'h0000;
        m_done_ready    = rand_ready ? ($urandom_range(3) != 0) : ready_on;
    endtask

    // One clock: sample handshakes at the negedge, retire them after the posedge.
    task automatic step();
        bit sp;
        bit ba;
        logic [12:0] e;
        @(negedge clk);
        cyc++;
        sp = s_slot_valid && s_slot_ready;
        ba = s_match_valid && s_match_ready;
        if (ba && s_match_eop && eop_cyc < 0) eop_cyc = cyc;
        if (ba && !s_match_eop && eop_cyc >= 0 && first_cyc < 0) first_cyc = cyc;
        if (m_done_valid && !prev_dv && dv_cyc < 0) dv_cyc = cyc;
        prev_dv = m_done_valid;
        if (m_done_valid && m_done_ready) begin
            chk("record_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("record", 32'({m_done_slot, m_done_count, m_done_overflow}), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        if (sp) void'(slot_q.pop_front());
        if (ba) void'(beat_q.pop_front());
        drive();
    endtask

    task automatic add_packet(input logic [7:0] slot);
        int n;
        int c;
        n = pkt_rules.size();
        c = n > 8 ? 8 : n;
        slot_q.push_back(slot);
        foreach (pkt_rules[i]) beat_q.push_back('{eop: 1'b0, rule: pkt_rules[i]});
        beat_q.push_back('{eop: 1'b1, rule: 16'h0000});
        exp_q.push_back({slot, 4'(c), n > 8});
        for (int i = 0; i < c; i++) begin
            ref_mem[7'(slot[3:0]) * 8 + i] = pkt_rules[i];
            ref_ok[7'(slot[3:0]) * 8 + i]  = 1;
        end
        total_ref += 32'(n);
        pkt_rules.delete();
        drive();
    endtask

    task automatic run_idle(input int budget);
        int k = 0;
        while ((slot_q.size() + beat_q.size() + exp_q.size()) > 0 && k < budget) begin
            step();
            k++;
        end
        chk("drain_in_budget", 32'(slot_q.size() + beat_q.size() + exp_q.size()), 32'd0);
        step();
    endtask

    task automatic rd_check(input logic [6:0] addr, input logic [15:0] exp);
        rd_en   = 1'b1;
        rd_addr = addr;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        @(negedge clk);
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_data", 32'(rd_data), 32'(exp));
        @(negedge clk);
        chk("rd_valid_pulse", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_s_slot_ready", 32'(s_slot_ready), 32'd0);
        chk("rst_s_match_ready", 32'(s_match_ready), 32'd0);
        chk("rst_m_done_valid", 32'(m_done_valid), 32'd0);
        chk("rst_m_done_rec", 32'({m_done_slot, m_done_count, m_done_overflow}), 32'd0);
        chk("rst_rd", 32'({rd_data, rd_valid}), 32'd0);
        chk("rst_total", total_matches, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] r8;
        logic [15:0] r0;
        logic [15:0] r1;
        int k;
        foreach (ref_ok[i]) ref_ok[i] = 0;
        #12;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();

        pkt_rules = '{16'h0011, 16'h0022, 16'h0033};
        add_packet(8'd3);
        run_idle(50);
        chk("t1_total", total_matches, total_ref);
        rd_check(7'd24, 16'h0011);
        rd_check(7'd25, 16'h0022);
        rd_check(7'd26, 16'h0033);

        add_packet(8'd5);
        run_idle(50);
        chk("t2_total_unchanged", total_matches, 32'd3);

        for (int i = 0; i < 10; i++) pkt_rules.push_back(16'($urandom));
        r8 = pkt_rules[7];
        add_packet(8'd1);
        run_idle(60);
        chk("t3_total", total_matches, 32'd13);
        rd_check(7'd15, r8);

        eop_cyc = -1; dv_cyc = -1; first_cyc = -1;
        pkt_rules.push_back(16'($urandom));
        add_packet(8'd2);
        pkt_rules = '{16'hbeef, 16'h1234};
        add_packet(8'd4);
        run_idle(50);
        chk("b2b_done_latency", 32'(dv_cyc - eop_cyc), 32'd2);
        chk("b2b_next_accept", 32'(first_cyc - eop_cyc), 32'd3);
        chk("b2b_total", total_matches, total_ref);

        ready_on = 1'b0;
        drive();
        for (int i = 0; i < 17; i++) begin
            pkt_rules.push_back(16'($urandom));
            add_packet(8'(16 + i));
        end
        repeat (120) step();
        chk("full_tag_pending", 32'(slot_q.size()), 32'd1);
        chk("full_stall_match_ready", 32'(s_match_ready), 32'd0);
        chk("full_no_tag_pop", 32'(s_slot_ready), 32'd0);
        chk("full_done_valid", 32'(m_done_valid), 32'd1);
        ready_on = 1'b1;
        drive();
        step();
        step();
        chk("full_resume_push", 32'(slot_q.size()), 32'd0);
        run_idle(100);
        chk("full_total", total_matches, total_ref);

        for (int i = 0; i < 5; i++) pkt_rules.push_back(16'($urandom));
        add_packet(8'd6);
        k = 0;
        while (beat_q.size() > 4 && k < 20) begin
            step();
            k++;
        end
        chk("mid_two_accepted", 32'(beat_q.size()), 32'd4);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        slot_q.delete();
        beat_q.delete();
        exp_q.delete();
        total_ref = '0;
        foreach (ref_ok[i]) ref_ok[i] = 0;
        prev_dv = 0;
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        r0 = 16'($urandom);
        r1 = 16'($urandom);
        pkt_rules = '{r0, r1};
        add_packet(8'd6);
        run_idle(50);
        chk("post_rst_total", total_matches, 32'd2);
        rd_check(7'd48, r0);
        rd_check(7'd49, r1);

        bubbles = 1;
        rand_ready = 1;
        for (int p = 0; p < 30; p++) begin
            k = $urandom_range(11);
            for (int i = 0; i < k; i++) pkt_rules.push_back(16'($urandom));
            add_packet(8'($urandom));
        end
        run_idle(3000);
        chk("rand_total", total_matches, total_ref);
        bubbles = 0;
        rand_ready = 0;
        drive();
        for (int a = 0; a < 128; a++)
            if (ref_ok[a]) rd_check(7'(a), ref_mem[a]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pigasus_match_collector.md
# pigasus_match_collector

Downstream companion to the Pigasus SME accelerator wrapper. It drains the per-packet match stream (rule IDs plus an end-of-packet marker) without core intervention and stores up to MAX_MATCHES rule IDs per packet slot in an on-chip buffer. It also pushes one completion record {slot, count, overflow} per packet into a completion FIFO that the RISC-V core polls over its I/O bus. This removes the per-match `match_release` round trip from core firmware.

## Interface
Parameters:
- SLOT_COUNT, 16, number of packet slots; power of two; also the completion FIFO depth.
- MAX_MATCHES, 8, rule IDs stored per slot; power of two.
- RULE_WIDTH, 16, rule ID width.
- SLOT_WIDTH, 8, slot tag width on slot and completion ports.
- CNT_WIDTH, $clog2(MAX_MATCHES+1), match count width.
- RD_ADDR_WIDTH, $clog2(SLOT_COUNT*MAX_MATCHES), buffer read address width.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous and active-high.
- s_slot_valid  in  1  slot tag available; in order of packets fed to the SME.
- s_slot  in  SLOT_WIDTH  slot tag; low $clog2(SLOT_COUNT) bits index the buffer.
- s_slot_ready  out  1  one-cycle pop pulse for the slot tag.
- s_match_valid  in  1  match beat valid.
- s_match_rule_id  in  RULE_WIDTH  matched rule ID; ignored on EOP beats.
- s_match_eop  in  1  beat is the end-of-packet marker and carries no rule.
- s_match_ready  out  1  match beat accepted when valid&ready.
- m_done_valid  out  1  completion record available.
- m_done_slot  out  SLOT_WIDTH  slot of the completed packet.
- m_done_count  out  CNT_WIDTH  number of stored rule IDs, 0..MAX_MATCHES.
- m_done_overflow  out  1  more than MAX_MATCHES matches were seen.
- m_done_ready  in  1  core pops the record.
- rd_en  in  1  buffer read strobe.
- rd_addr  in  RD_ADDR_WIDTH  {slot_idx, match_idx}.
- rd_data  out  RULE_WIDTH  read data.
- rd_valid  out  1  rd_data valid.
- total_matches  out  32  free-running count of accepted non-EOP beats; wraps.

## Operation
- FSM states: IDLE, COLLECT, COMMIT.
- IDLE:
  - s_match_ready=0.
  - When s_slot_valid=1, latch s_slot, clear idx and overflow, and go to COLLECT. The slot tag is not popped yet.
- COLLECT:
  - s_match_ready=1.
  - Accepted non-EOP beat with idx<MAX_MATCHES: write the rule ID to buf[{slot_idx, idx}], then idx+1.
  - Accepted non-EOP beat with idx==MAX_MATCHES: discard the rule ID, set overflow, leave idx saturated.
  - Accepted EOP beat: go to COMMIT.
- COMMIT:
  - s_match_ready=0.
  - If the completion FIFO is not full: push {slot, idx, overflow}, pulse s_slot_ready for one cycle, go to IDLE.
  - If the FIFO is full: stay in COMMIT (backpressures the SME).
- Packet with zero matches (EOP first): record with count=0, overflow=0.
- total_matches increments on every accepted non-EOP beat, including overflow-discarded beats.
- Buffer: SLOT_COUNT*MAX_MATCHES x RULE_WIDTH, simple dual-port RAM, read-first.
  - Not cleared by reset.
  - Entries at or above count are stale.
- Read port: rd_en samples rd_addr, returning rd_data and rd_valid one cycle later.
- Read and write to the same address in the same cycle returns the old data. Firmware reads a slot only after popping its completion.
- Reset (asynchronous, any time, including mid-packet): the FSM returns to IDLE and the completion FIFO empties. The partial packet is lost; the buffer is untouched.
- Reset values of all outputs:
  - s_slot_ready=0, s_match_ready=0, m_done_valid=0.
  - m_done_slot/count/overflow=0, rd_data=0, rd_valid=0, total_matches=0.

## Timing
- Slot tag available in IDLE → COLLECT next cycle; the first match can be accepted in that cycle.
- One match accepted per cycle, sustained, in COLLECT.
- EOP accepted at cycle T → COMMIT at T+1 (push if not full) → m_done_valid at T+2 when the FIFO was empty.
- Next packet's COLLECT no earlier than T+3 (through IDLE).
- Completion FIFO has registered outputs: pop when m_done_valid&m_done_ready. A simultaneous push and pop while full is not allowed; COMMIT waits one cycle.
- Completion FIFO full: the SME is stalled via s_match_ready=0 in COMMIT; no records are dropped.
- rd latency is 1 cycle; rd_valid is a one-cycle pulse per rd_en.

## Structure
- Shared package holds:
  - the FSM state encoding;
  - the completion record field widths/layout {slot, count, overflow};
  - rd_addr field split constants.
- One sub-module: collector_done_fifo. Parameterised depth/width, async active-high reset, registered dout, valid/ready on both sides, full/empty flags.
- The buffer RAM is inferred inline in the top level.

## Test plan
- Slot 3, rule IDs 0x0011, 0x0022, 0x0033, then EOP → record {3, 3, 0}; reading addr {3,0..2} returns 0x0011/0x0022/0x0033 one cycle after each rd_en.
- Slot 5 with EOP only → record {5, 0, 0}; total_matches unchanged.
- Slot 1 with 10 matches (MAX_MATCHES=8) → record {1, 8, 1}; addr {1,7} holds the 8th ID; total_matches +10.
- Hold m_done_ready=0 over 17 packets → after 16 records, the FSM sits in COMMIT with s_match_ready=0; one pop → the 17th record is pushed and the flow resumes with no loss.
- Back-to-back: EOP at T with the next slot tag present → m_done_valid at T+2; the next packet's first match is accepted at T+3.
- Assert rst mid-packet after 2 matches:
  - all outputs go to reset values immediately;
  - no record is produced;
  - after release, a new packet collects from idx 0.
